// File: rtl/ldl_arb_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package ldl_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Every weight register comes out of reset granting one packet per turn.
  localparam int WEIGHT_RST = 1;

  // Modulo increment that also works when width is not a power of two.
  function automatic int wrap_inc(input int idx, input int width);
    return (idx >= width - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Combinational rotating priority picker: first set request at or above
// ptr, wrapping from WIDTH-1 back to 0.
module ldl_rr_pick #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  // Scan from the farthest offset back to the nearest so the closest
  // requester to ptr is the last one written and therefore wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= WIDTH) j = j - WIDTH;
      if (i_req[j]) begin
        o_idx   = IW'(j);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldl_wrr_arb.sv
// Weighted round-robin packet arbiter. A grant is held for whole packets
// (delimited by last) and for up to weight[owner] packets per turn; every
// turn ends with one IDLE cycle while the next owner is picked.
module ldl_wrr_arb
  import ldl_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int WW    = 4,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] last,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WW-1:0]    cfg_wdata,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IW-1:0]    gnt_bin,
  output logic [WIDTH-1:0] gnt_hot,
  output logic             busy
);

  arb_state_e       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_sel;
  logic [WW-1:0]    r_credit;
  logic [WW-1:0]    r_weight [WIDTH];
  logic             r_gnt_valid;
  logic [IW-1:0]    r_gnt_bin;
  logic [WIDTH-1:0] r_gnt_hot;

  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_valid;
  logic [WW-1:0]    w_load_credit;
  logic             w_idx_ok;
  logic             w_pkt_end;
  logic             w_hold;

  ldl_rr_pick #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // An index width that exactly covers WIDTH cannot go out of range.
  generate
    if ((1 << IW) == WIDTH) begin : g_pow2
      assign w_idx_ok = 1'b1;
    end else begin : g_npow2
      assign w_idx_ok = (int'(cfg_idx) < WIDTH);
    end
  endgenerate

  // A zero weight still grants one packet so a requester is never starved.
  assign w_load_credit = (r_weight[w_pick_idx] == '0) ? WW'(1)
                                                     : r_weight[w_pick_idx];

  // Packet end on the owner's accepted last beat; hold only while the
  // owner keeps requesting and has packets left in its turn.
  assign w_pkt_end = r_gnt_valid & gnt_ready & last[r_sel];
  assign w_hold    = (r_credit > WW'(1)) & req[r_sel];

  // Weight file; writes only affect future credit loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) r_weight[i] <= WW'(WEIGHT_RST);
    end else if (cfg_we && w_idx_ok) begin
      r_weight[cfg_idx] <= cfg_wdata;
    end
  end

  // Grant FSM with registered outputs, credit counter and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_sel       <= '0;
      r_credit    <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_bin   <= '0;
      r_gnt_hot   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_sel       <= w_pick_idx;
            r_credit    <= w_load_credit;
            r_gnt_valid <= 1'b1;
            r_gnt_bin   <= w_pick_idx;
            r_gnt_hot   <= WIDTH'(1) << w_pick_idx;
            r_state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_pkt_end) begin
            if (w_hold) begin
              r_credit <= r_credit - WW'(1);
            end else begin
              r_ptr       <= IW'(wrap_inc(int'(r_sel), WIDTH));
              r_gnt_valid <= 1'b0;
              r_gnt_hot   <= '0;
              r_state     <= ARB_IDLE;
            end
          end
        end
        default: begin
          r_gnt_valid <= 1'b0;
          r_gnt_hot   <= '0;
          r_state     <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt_valid = r_gnt_valid;
  assign gnt_bin   = r_gnt_bin;
  assign gnt_hot   = r_gnt_hot;
  assign busy      = r_gnt_valid;

endmodule

// File: tb/tb_ldl_wrr_arb.sv
// Bench for ldl_wrr_arb: one WIDTH=8 and one WIDTH=5 instance, directed
// scenarios plus random traffic, all compared against a turn-level model.
module tb_ldl_wrr_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] t_req  [2];
  logic [7:0] t_last [2];
  logic       t_rdy  [2];
  logic       t_we;
  logic [2:0] t_idx;
  logic [3:0] t_wd;

  logic       gv8, busy8, gv5, busy5;
  logic [2:0] gb8, gb5;
  logic [7:0] gh8;
  logic [4:0] gh5;
  logic [7:0] req8, last8;
  logic [4:0] req5, last5;
  logic       rdy8, rdy5;

  assign req8  = t_req[0];
  assign last8 = t_last[0];
  assign rdy8  = t_rdy[0];
  assign req5  = t_req[1][4:0];
  assign last5 = t_last[1][4:0];
  assign rdy5  = t_rdy[1];

  ldl_wrr_arb #(.WIDTH(8), .WW(4)) u_d8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .last(last8),
    .cfg_we(t_we), .cfg_idx(t_idx), .cfg_wdata(t_wd),
    .gnt_valid(gv8), .gnt_ready(rdy8), .gnt_bin(gb8), .gnt_hot(gh8),
    .busy(busy8));

  ldl_wrr_arb #(.WIDTH(5), .WW(4)) u_d5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .last(last5),
    .cfg_we(t_we), .cfg_idx(t_idx), .cfg_wdata(t_wd),
    .gnt_valid(gv5), .gnt_ready(rdy5), .gnt_bin(gb5), .gnt_hot(gh5),
    .busy(busy5));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the channel, how many packets remain in the
  // owner's turn, and where the next turn starts searching.
  int W [2] = '{8, 5};
  int m_w     [2][8];
  int m_ptr   [2];
  int m_owner [2];
  int m_left  [2];
  bit m_busy  [2];

  task automatic m_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 8; i++) m_w[u][i] = 1;
      m_ptr[u] = 0; m_owner[u] = 0; m_left[u] = 0; m_busy[u] = 0;
    end
  endtask

  task automatic m_step(input int u);
    int n;
    n = W[u];
    if (!m_busy[u]) begin
      bit found;
      found = 0;
      for (int k = 0; k < n && !found; k++) begin
        int j;
        j = (m_ptr[u] + k) % n;
        if (t_req[u][j]) begin
          found = 1;
          m_owner[u] = j;
          m_left[u] = (m_w[u][j] == 0) ? 1 : m_w[u][j];
          m_busy[u] = 1;
        end
      end
    end else if (t_rdy[u] && t_last[u][m_owner[u]]) begin
      if (m_left[u] > 1 && t_req[u][m_owner[u]]) m_left[u]--;
      else begin
        m_busy[u] = 0;
        m_ptr[u] = (m_owner[u] + 1) % n;
      end
    end
    if (t_we && int'(t_idx) < n) m_w[u][t_idx] = int'(t_wd);
  endtask

  function automatic logic [7:0] obs_hot(input int u);
    return (u == 0) ? gh8 : {3'b0, gh5};
  endfunction
  function automatic logic [2:0] obs_bin(input int u);
    return (u == 0) ? gb8 : gb5;
  endfunction
  function automatic logic obs_vld(input int u);
    return (u == 0) ? gv8 : gv5;
  endfunction
  function automatic logic obs_busy(input int u);
    return (u == 0) ? busy8 : busy5;
  endfunction

  task automatic check_outs();
    for (int u = 0; u < 2; u++) begin
      logic [7:0] eh;
      eh = m_busy[u] ? (8'd1 << m_owner[u]) : 8'd0;
      chk($sformatf("vld%0d", W[u]), obs_vld(u), m_busy[u]);
      chk($sformatf("hot%0d", W[u]), obs_hot(u), eh);
      chk($sformatf("busy%0d", W[u]), obs_busy(u), m_busy[u]);
      if (m_busy[u]) chk($sformatf("bin%0d", W[u]), obs_bin(u), m_owner[u]);
    end
  endtask

  // One clock: model follows the same edge, outputs checked at negedge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      m_step(0);
      m_step(1);
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic set_in(input logic [7:0] r8, input logic [7:0] r5,
                        input logic [7:0] l, input logic rdy);
    t_req[0] = r8; t_req[1] = r5;
    t_last[0] = l; t_last[1] = l;
    t_rdy[0] = rdy; t_rdy[1] = rdy;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [3:0] wd);
    set_in(8'h00, 8'h00, 8'h00, 1'b1);
    t_we = 1'b1; t_idx = idx; t_wd = wd;
    cycle();
    t_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    t_we = 1'b0;
    #1;
    chk("rst_vld8", gv8, 1'b0);
    chk("rst_hot8", gh8, 8'h00);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_vld5", gv5, 1'b0);
    m_reset();
    cycle();
    rst_n = 1'b1;
  endtask

  int exp_w[9] = '{0, 0, 0, -1, 1, -1, 0, 0, 0};
  int bp_pat[6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    int beats;
    t_we = 1'b0; t_idx = '0; t_wd = '0;
    set_in(8'h00, 8'h00, 8'h00, 1'b0);
    m_reset();
    repeat (2) @(negedge clk);
    do_reset();
    check_outs();

    // Basic rotation (0,7 on WIDTH=8) and wrap 4->0 on WIDTH=5.
    set_in(8'h81, 8'h11, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rot_vld8", gv8, (i % 2) == 0);
      chk("rot_vld5", gv5, (i % 2) == 0);
      if (i % 2 == 0) begin
        chk("rot_bin8", gb8, (i % 4 == 0) ? 3'd0 : 3'd7);
        chk("rot_bin5", gb5, (i % 4 == 0) ? 3'd0 : 3'd4);
      end
    end

    // Weighted burst: weight[0]=3, weight[1]=1.
    do_reset();
    cfg_write(3'd0, 4'd3);
    set_in(8'h03, 8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("wrr_vld", gv8, exp_w[i] >= 0);
      if (exp_w[i] >= 0) chk("wrr_bin", gb8, exp_w[i]);
    end

    // Multi-beat packet with backpressure on requester 2.
    set_in(8'h00, 8'h00, 8'hFF, 1'b1);
    repeat (4) cycle();
    set_in(8'h04, 8'h00, 8'h00, 1'b0);
    cycle();
    beats = 0;
    for (int p = 0; p < 6; p++) begin
      chk("bp_hot", gh8, 8'h04);
      set_in(8'h04, 8'h00, (p == 5) ? 8'h04 : 8'h00, bp_pat[p] != 0);
      if (gv8 && t_rdy[0]) beats++;
      cycle();
    end
    chk("bp_beats", beats, 4);
    chk("bp_done", gv8, 1'b0);

    // Weight 0 loads as one packet; index 6 is out of range for WIDTH=5.
    cfg_write(3'd3, 4'd0);
    cfg_write(3'd6, 4'd0);
    set_in(8'h08, 8'h08, 8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("w0_vld", gv8, (i % 2) == 0);
      if (i % 2 == 0) chk("w0_bin", gb8, 3'd3);
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int u = 0; u < 2; u++) begin
        t_req[u]  = 8'($urandom) & 8'($urandom);
        t_last[u] = 8'($urandom);
        t_rdy[u]  = ($urandom_range(0, 3) != 0);
      end
      t_we  = ($urandom_range(0, 9) == 0);
      t_idx = 3'($urandom);
      t_wd  = 4'($urandom);
      cycle();
    end
    t_we = 1'b0;

    // Reset in the middle of a packet to requester 5.
    set_in(8'h00, 8'h00, 8'hFF, 1'b1);
    repeat (4) cycle();
    set_in(8'h20, 8'h00, 8'h00, 1'b1);
    cycle();
    chk("pre_bin", gb8, 3'd5);
    cycle();
    chk("pre_vld", gv8, 1'b1);
    do_reset();
    set_in(8'h04, 8'h00, 8'h00, 1'b1);
    cycle();
    chk("post_vld", gv8, 1'b1);
    chk("post_bin", gb8, 3'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
